// File: rtl/mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_pkg : shared types and helpers for the mem_rw_pipe scratch RAM
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int RD_LAT_MAX = 4;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rd_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_rd_pipe : delay line of {valid, data}; each stage keeps its last valid data
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module mem_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [STAGES-1:0]     valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [STAGES];
  logic [DATA_WIDTH-1:0] data_d [STAGES];

  // Data only advances alongside a valid bit, so the output holds the last response.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    valid_d[0] = in_valid;
    data_d[0]  = in_valid ? in_data : data_q[0];
    for (int s = 1; s < STAGES; s++) begin
      valid_d[s] = valid_q[s-1];
      data_d[s]  = valid_q[s-1] ? data_q[s-1] : data_q[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mem_rw_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_rw_pipe : single-port RAM with valid/ready requests, byte enables,
//               pipelined read response and a post-reset init sweep
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module mem_rw_pipe
  import mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RD_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_wr,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]             req_wdata,
  input  logic [be_width(DATA_WIDTH)-1:0]   req_be,
  output logic                              rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              init_done
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam int BE_WIDTH = be_width(DATA_WIDTH);

  generate
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
      $fatal(1, "mem_rw_pipe: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
      $fatal(1, "mem_rw_pipe: RD_LATENCY must be within 1..%0d", RD_LAT_MAX);
    end
  endgenerate

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_WIDTH-1:0]   wbe;
  logic                  accept;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    req_ready = 1'b0;
    init_done = 1'b0;
    we        = 1'b0;
    waddr     = req_addr;
    wdata     = req_wdata;
    wbe       = req_be;
    case (state_q)
      INIT: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = INIT_VALUE;
        wbe   = '1;
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
        we        = req_valid && req_wr;
      end
    endcase
  end

  assign accept     = req_valid && req_ready;
  assign rd_valid_d = accept && !req_wr;
  assign rd_data_d  = rd_valid_d ? mem_q[req_addr] : rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage is not reset; the sweep that follows reset defines its contents.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wbe[i]) begin
          mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign rsp_valid = rd_valid_q;
      assign rsp_rdata = rd_data_q;
    end else begin : g_lat_pipe
      mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RD_LATENCY - 1)
      ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_valid_q),
        .in_data   (rd_data_q),
        .out_valid (rsp_valid),
        .out_data  (rsp_rdata)
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_rw_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_rw_pipe : directed bench driving latency-1, -2 and -4 instances in lockstep
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module tb_mem_rw_pipe;

  localparam int NI = 3;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;

  logic        req_ready [NI];
  logic        rsp_valid [NI];
  logic        init_done [NI];
  logic [31:0] rsp_rdata [NI];

  exp_t        exp_q [NI][$];
  logic [31:0] last_data [NI];
  int          n_cmp = 0;
  int          n_err = 0;
  int          edge_n = 0;

  always #5 clk = ~clk;

  mem_rw_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .init_done(init_done[0]));

  mem_rw_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .init_done(init_done[1]));

  mem_rw_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[2]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .init_done(init_done[2]));

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: observed %h required %h", tag, act, req);
    end
  endtask

  // A read accepted at edge k is observed valid just after edge k+L-1, so a
  // consumer capturing on edge k+L sees it.
  task automatic check_rsp();
    for (int i = 0; i < NI; i++) begin
      logic due;
      due = (exp_q[i].size() > 0) && (exp_q[i][0].due == edge_n);
      chk($sformatf("rsp_valid L%0d edge%0d", lat_of(i), edge_n),
          {31'b0, rsp_valid[i]}, {31'b0, due});
      if (due) begin
        chk($sformatf("rsp_rdata L%0d edge%0d", lat_of(i), edge_n),
            rsp_rdata[i], exp_q[i][0].data);
        last_data[i] = exp_q[i][0].data;
        void'(exp_q[i].pop_front());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    #1;
    check_rsp();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    step();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp_data);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_wdata = '0; req_be = '0;
    for (int i = 0; i < NI; i++) begin
      exp_q[i].push_back('{due: edge_n + lat_of(i), data: exp_data});
    end
    step();
  endtask

  task automatic drain(input string tag);
    req_valid = 1'b0;
    repeat (6) step();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s hold L%0d", tag, lat_of(i)), rsp_rdata[i], last_data[i]);
    end
  endtask

  // Holds a write of zero to addr 2 throughout the sweep; it must be ignored.
  task automatic wait_init(input string tag);
    int cnt;
    cnt = 0;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd2; req_wdata = '0; req_be = 4'hF;
    while (req_ready[0] === 1'b0 && cnt < 40) begin
      cnt++;
      step();
    end
    chk($sformatf("%s busy cycles", tag), cnt, 32'd16);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s ready L%0d", tag, lat_of(i)), {31'b0, req_ready[i]}, 32'd1);
      chk($sformatf("%s init_done L%0d", tag, lat_of(i)), {31'b0, init_done[i]}, 32'd1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s ready L%0d", tag, lat_of(i)), {31'b0, req_ready[i]}, 32'd0);
      chk($sformatf("%s init_done L%0d", tag, lat_of(i)), {31'b0, init_done[i]}, 32'd0);
      chk($sformatf("%s rdata L%0d", tag, lat_of(i)), rsp_rdata[i], 32'd0);
      last_data[i] = 32'd0;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd2; req_wdata = '0; req_be = 4'hF;
    repeat (3) step();
    check_reset_state("reset");
    rst = 1'b0;
    wait_init("init1");

    for (int a = 0; a < 16; a++) begin
      rd(4'(a), 32'hFFFF_FFFF);
    end
    drain("sweep");

    wr(4'd3, 32'hDEAD_BEEF, 4'hF);
    rd(4'd3, 32'hDEAD_BEEF);
    drain("full_write");

    wr(4'd3, 32'h1122_3344, 4'b0101);
    rd(4'd3, 32'hDE22_BE44);
    wr(4'd3, 32'h0BAD_F00D, 4'b0000);
    rd(4'd3, 32'hDE22_BE44);
    drain("byte_en");

    wr(4'd0, 32'h0000_00A0, 4'hF);
    wr(4'd1, 32'h0000_00A1, 4'hF);
    wr(4'd2, 32'h0000_00A2, 4'hF);
    wr(4'd3, 32'h0000_00A3, 4'hF);
    rd(4'd0, 32'h0000_00A0);
    rd(4'd1, 32'h0000_00A1);
    rd(4'd2, 32'h0000_00A2);
    rd(4'd3, 32'h0000_00A3);
    drain("burst");

    wr(4'd5, 32'h0000_0055, 4'hF);
    req_valid = 1'b0;
    step();
    rd(4'd5, 32'h0000_0055);
    wr(4'd5, 32'h0000_0066, 4'hF);
    wr(4'd5, 32'h0000_0077, 4'hF);
    rd(4'd5, 32'h0000_0077);
    drain("ordering");

    wr(4'd9, 32'h0000_0099, 4'hF);
    rd(4'd9, 32'h0000_0099);
    drain("pre_reset");
    rd(4'd9, 32'h0000_0099);
    rd(4'd9, 32'h0000_0099);
    // Responses that would land on or after the reset edge are dropped.
    for (int i = 0; i < NI; i++) begin
      while (exp_q[i].size() > 0 && exp_q[i][exp_q[i].size()-1].due > edge_n) begin
        void'(exp_q[i].pop_back());
      end
    end
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (3) step();
    check_reset_state("mid_reset");
    rst = 1'b0;
    wait_init("init2");
    rd(4'd9, 32'hFFFF_FFFF);
    rd(4'd2, 32'hFFFF_FFFF);
    drain("reinit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_rw_pipe.md
Name: mem_rw_pipe

Overview:
- Parametrised single-port synchronous memory, successor to the 8-bit/4-entry memory.
- Adds a valid/ready request interface, per-byte write enables, configurable read latency with a pipelined response, and a hardware init sweep after reset.
- Sits between a bus/test master and local storage. Serves as the general scratch RAM for the block-level environments.

Parameters:
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, word width; must be a multiple of 8; BE_WIDTH = DATA_WIDTH/8.
- RD_LATENCY, 2, accept-to-response cycles for reads; legal range 1..4.
- INIT_VALUE, all ones, value written to every entry by the init sweep.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  BE_WIDTH  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  read data valid; one-cycle pulse per accepted read.
- rsp_rdata  out  DATA_WIDTH  read data.
- init_done  out  1  high once the init sweep has completed.

Behaviour:
- Reset values (rst high at an edge): state=INIT, init pointer=0, all pipeline valid bits=0, rsp_valid=0, rsp_rdata=0, req_ready=0, init_done=0.
- FSM state INIT:
  - Each cycle, writes INIT_VALUE to mem[ptr], then ptr++.
  - After the write to DEPTH-1, moves to RUN.
  - INIT lasts exactly DEPTH cycles after the first edge with rst low.
  - req_ready=0 throughout; requests are ignored, not queued.
- FSM state RUN:
  - req_ready=1 and init_done=1 (both combinational from state).
  - Stays in RUN until rst.
- Accept: req_valid && req_ready at an edge. One request is accepted per cycle, with no bubbles.
- Write accept:
  - For each i with req_be[i]=1, mem[addr] byte i takes wdata byte i. Other bytes are unchanged.
  - be=0 is a legal no-op.
  - Writes produce no response.
- Read accept:
  - mem[addr] is sampled at the accept edge into pipeline stage 1, then shifted through RD_LATENCY-1 further stages.
  - rsp_valid=1 exactly RD_LATENCY cycles after the accept edge, for one cycle.
  - Back-to-back reads give back-to-back responses, in order.
- Ordering (single port):
  - Write accepted at edge t, read of the same address at t+1 → returns the new data.
  - Read at t, write to the same address at t+1 → returns the old data.
- rsp_rdata holds its last value while rsp_valid=0. It is not cleared between responses.
- Address wrap: all ADDR_WIDTH values are in range, so there is no error case.
- Reset mid-operation:
  - All in-flight reads are dropped; no rsp_valid after rst.
  - Memory is re-initialised by a new sweep.
  - rst held for N cycles keeps the block in INIT with ptr=0; the sweep starts on the first edge with rst low.
- req_valid during INIT: no effect on memory or the pipeline.
- Illegal parameters (DATA_WIDTH%8≠0, RD_LATENCY outside 1..4): elaboration-time fatal.

Decomposition:
- Package mem_pkg holds:
  - state enum {INIT, RUN};
  - localparam RD_LAT_MAX=4;
  - a function computing BE_WIDTH from DATA_WIDTH.
- Sub-module mem_rd_pipe: parametrised delay line of {valid, data} of depth RD_LATENCY-1, with synchronous clear on rst.
- The top level holds the array, FSM, init pointer and byte-enable write logic.

Test Plan:
- Release rst, hold req_valid=1 from the start → req_ready=0 for exactly 16 cycles, then init_done=1. Read every address → 32'hFFFFFFFF on each; memory unchanged by the requests made during INIT.
- Write addr 3 = 32'hDEADBEEF, be=4'hF; read addr 3 → rsp_valid exactly 2 cycles after the read accept, rsp_rdata=32'hDEADBEEF.
- After that, write addr 3 = 32'h11223344 with be=4'b0101; read addr 3 → 32'hDE22BE44. Then write with be=0 and read → value unchanged.
- Reads of addrs 0,1,2,3 on consecutive cycles after writing 0xA0..0xA3 → four consecutive rsp_valid pulses with data 0xA0,0xA1,0xA2,0xA3 in order. Repeat with RD_LATENCY=1 and RD_LATENCY=4.
- Read addr 5 (old 0x55) then write addr 5 = 0x66 on the next cycle → response 0x55. Write 0x77 then read on the next cycle → response 0x77.
- Accept reads at two consecutive cycles, then assert rst one cycle later → no rsp_valid ever appears. The init sweep reruns for 16 cycles, and a read of a previously written address returns all ones.
